// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'hBFC00000;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_tag_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; storage is reset so an empty head reads 0.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push && !clear_i) mem_q[wr_q] <= data_i;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-limited in-order instruction fetch: tags each request with its PC,
// pairs responses with tags and queues them toward decode; redirects drop stale work.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PC_i,
    input  logic [DATA_WIDTH-1:0] PC_Plus4_i,
    input  logic                  flush_i,
    output logic                  imem_req_valid_o,
    output logic [DATA_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] instr_pc_o,
    output logic [DATA_WIDTH-1:0] instr_pc_plus4_o,
    input  logic                  instr_ready_i,
    output logic                  fetch_stall_o
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned TAG_W = $bits(fetch_tag_t);
    localparam int unsigned ENT_W = $bits(fetch_entry_t);

    fetch_tag_t   tag_in, tag_head;
    fetch_entry_t ent_in, ent_head;
    logic [CW-1:0] tag_cnt, out_cnt, used;
    logic [CW-1:0] drop_q, drop_d;
    logic tag_full, tag_empty, out_full, out_empty;
    logic req_fire, rsp_fire, discard, out_push, out_pop;

    // Tag FIFO holds both live and to-be-dropped requests, so it covers inflight + drop.
    assign used      = tag_cnt + out_cnt;
    assign req_fire  = imem_req_valid_o && imem_req_ready_i;
    assign rsp_fire  = imem_rsp_valid_i && !tag_empty;
    assign discard   = flush_i || (drop_q != '0);
    assign out_push  = rsp_fire && !discard && !out_full;
    assign out_pop   = instr_valid_o && instr_ready_i;

    assign imem_req_valid_o = !rst && !flush_i && (used < CW'(DEPTH)) && !tag_full;
    assign imem_req_addr_o  = PC_i;
    assign fetch_stall_o    = !rst && !flush_i && !req_fire;

    assign tag_in.pc       = XLEN'(PC_i);
    assign tag_in.pc_plus4 = XLEN'(PC_Plus4_i);
    assign ent_in.instr    = XLEN'(imem_rsp_data_i);
    assign ent_in.pc       = tag_head.pc;
    assign ent_in.pc_plus4 = tag_head.pc_plus4;

    // On redirect every tag still outstanding after this cycle's response must be dropped.
    always_comb begin
        drop_d = drop_q;
        if (flush_i) begin
            drop_d = tag_cnt - CW'(rsp_fire);
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_q <= '0;
        else     drop_q <= drop_d;
    end

    fetch_fifo #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_fire),
        .data_i  (tag_in),
        .pop_i   (rsp_fire),
        .clear_i (1'b0),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_cnt)
    );

    fetch_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (out_push),
        .data_i  (ent_in),
        .pop_i   (out_pop),
        .clear_i (flush_i),
        .data_o  (ent_head),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_cnt)
    );

    assign instr_valid_o    = !out_empty;
    assign instr_o          = DATA_WIDTH'(ent_head.instr);
    assign instr_pc_o       = DATA_WIDTH'(ent_head.pc);
    assign instr_pc_plus4_o = DATA_WIDTH'(ent_head.pc_plus4);

    // A response with no outstanding tag is a memory protocol violation.
    rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid_i && tag_empty));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: PC register and memory models with an in-order scoreboard.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH_TB = 4;

    logic        clk, rst;
    logic [31:0] PC_i, PC_Plus4_i;
    logic        flush_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o, instr_pc_o, instr_pc_plus4_o;
    logic        instr_ready_i;
    logic        fetch_stall_o;

    instr_fetch_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH_TB)) dut (
        .clk              (clk),
        .rst              (rst),
        .PC_i             (PC_i),
        .PC_Plus4_i       (PC_Plus4_i),
        .flush_i          (flush_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_pc_plus4_o (instr_pc_plus4_o),
        .instr_ready_i    (instr_ready_i),
        .fetch_stall_o    (fetch_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pc, target;
    logic        mem_rdy, dec_rdy, flush;
    int          lat, cyc;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] sb_pc[$];
    logic        s_valid, s_stall, s_ivalid, s_acc, popped;
    logic [31:0] s_addr, s_ipc, popped_pc;
    int          checks, failures;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // One clock cycle: drive inputs, sample outputs, score pops, advance models.
    task automatic tick();
        logic [31:0] exp;
        PC_i             = pc;
        PC_Plus4_i       = pc + 32'd4;
        imem_req_ready_i = mem_rdy;
        instr_ready_i    = dec_rdy;
        flush_i          = flush;
        if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = word_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = INSTR_NOP;
        end
        #1;
        s_valid  = imem_req_valid_o;
        s_addr   = imem_req_addr_o;
        s_stall  = fetch_stall_o;
        s_ivalid = instr_valid_o;
        s_ipc    = instr_pc_o;
        s_acc    = s_valid && mem_rdy;
        popped   = 1'b0;
        if (s_valid) begin
            checks++;
            if (s_addr !== pc) begin
                failures++;
                $display("FAIL req_addr: got %h want %h", s_addr, pc);
            end
        end
        if (flush) begin
            sb_pc.delete();
        end else if (s_ivalid && dec_rdy) begin
            popped    = 1'b1;
            popped_pc = s_ipc;
            checks++;
            if (sb_pc.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got pc=%h want no instruction", s_ipc);
            end else begin
                exp = sb_pc.pop_front();
                if (instr_pc_o !== exp || instr_pc_plus4_o !== exp + 32'd4 || instr_o !== word_of(exp)) begin
                    failures++;
                    $display("FAIL sb_entry: got pc=%h p4=%h instr=%h want pc=%h p4=%h instr=%h",
                             instr_pc_o, instr_pc_plus4_o, instr_o, exp, exp + 32'd4, word_of(exp));
                end
            end
        end
        @(posedge clk);
        if (s_acc) begin
            mq_addr.push_back(pc);
            mq_due.push_back(cyc + lat);
            sb_pc.push_back(pc);
        end
        if (rst)           pc = RESET_PC;
        else if (flush)    pc = target;
        else if (!s_stall) pc = pc + 32'd4;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        mem_rdy = 1'b0; dec_rdy = 1'b1; flush = 1'b0;
        while ((sb_pc.size() != 0 || mq_addr.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (sb_pc.size() != 0 || mq_addr.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d expected and %0d mem pending want 0", name, sb_pc.size(), mq_addr.size());
        end
        tick();
        checks++;
        if (s_ivalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_valid: got %b want 0", name, s_ivalid);
        end
    endtask

    task automatic wait_first_pop(input string name, input logic [31:0] want);
        int n;
        n = 0;
        mem_rdy = 1'b1; dec_rdy = 1'b1; flush = 1'b0; lat = 1;
        popped = 1'b0;
        while (!popped && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (!popped || popped_pc !== want) begin
            failures++;
            $display("FAIL %s_first_pc: got popped=%b pc=%h want pc=%h", name, popped, popped_pc, want);
        end
    endtask

    task automatic do_reset();
        flush = 1'b0; mem_rdy = 1'b0; dec_rdy = 1'b0; rst = 1'b1;
        tick();
        tick();
        mq_addr.delete(); mq_due.delete(); sb_pc.delete();
        rst = 1'b0;
        pc  = RESET_PC;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({imem_req_valid_o, fetch_stall_o, instr_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b stall=%b ivalid=%b want 000", imem_req_valid_o, fetch_stall_o, instr_valid_o);
        end
        checks++;
        if (instr_o !== 32'd0 || instr_pc_o !== 32'd0 || instr_pc_plus4_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: got %h %h %h want 0", instr_o, instr_pc_o, instr_pc_plus4_o);
        end
        @(negedge clk);
        rst = 1'b0;
        pc  = RESET_PC;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        exp_pc = RESET_PC;
        mem_rdy = 1'b1; dec_rdy = 1'b1; flush = 1'b0; lat = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (s_stall !== 1'b0) begin
                failures++;
                $display("FAIL zw_stall: cycle %0d got %b want 0", i, s_stall);
            end
            if (i >= 2) begin
                checks++;
                if (!popped || popped_pc !== exp_pc) begin
                    failures++;
                    $display("FAIL zw_stream: cycle %0d got valid=%b pc=%h want pc=%h", i, popped, popped_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
        drain("zw");
    endtask

    task automatic test_decode_backpressure();
        int acc;
        acc = 0;
        do_reset();
        mem_rdy = 1'b1; dec_rdy = 1'b0; lat = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_acc) acc++;
            if (s_ivalid) begin
                checks++;
                if (s_ipc !== RESET_PC) begin
                    failures++;
                    $display("FAIL dbp_head: got %h want %h", s_ipc, RESET_PC);
                end
            end
        end
        checks++;
        if (s_valid !== 1'b0 || s_stall !== 1'b1) begin
            failures++;
            $display("FAIL dbp_full: got req=%b stall=%b want req=0 stall=1", s_valid, s_stall);
        end
        checks++;
        if (acc != int'(DEPTH_TB)) begin
            failures++;
            $display("FAIL dbp_accepted: got %0d want %0d", acc, DEPTH_TB);
        end
        acc = 0;
        dec_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_acc) acc++;
        end
        checks++;
        if (acc == 0) begin
            failures++;
            $display("FAIL dbp_resume: got %0d accepted want >0", acc);
        end
        drain("dbp");
    endtask

    task automatic test_mem_backpressure();
        logic [31:0] held;
        held = pc;
        mem_rdy = 1'b0; dec_rdy = 1'b1; flush = 1'b0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_stall !== 1'b1 || s_valid !== 1'b1 || s_addr !== held) begin
                failures++;
                $display("FAIL mbp_hold: got stall=%b req=%b addr=%h want 1 1 %h", s_stall, s_valid, s_addr, held);
            end
        end
        wait_first_pop("mbp", held);
        drain("mbp");
    endtask

    task automatic test_flush_inflight();
        target = 32'hBFC00100;
        dec_rdy = 1'b0; mem_rdy = 1'b1; flush = 1'b0;
        lat = 1; tick();
        lat = 3; tick();
        lat = 3; tick();
        flush = 1'b1;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_stall !== 1'b0 || s_ivalid !== 1'b1) begin
            failures++;
            $display("FAIL fl_cycle: got req=%b stall=%b ivalid=%b want 0 0 1", s_valid, s_stall, s_ivalid);
        end
        flush = 1'b0; lat = 1; dec_rdy = 1'b1;
        tick();
        checks++;
        if (s_ivalid !== 1'b0 || s_valid !== 1'b1 || s_addr !== target) begin
            failures++;
            $display("FAIL fl_after: got ivalid=%b req=%b addr=%h want 0 1 %h", s_ivalid, s_valid, s_addr, target);
        end
        wait_first_pop("fl", target);
        drain("fl");
    endtask

    task automatic test_flush_coincident();
        int acc;
        target = 32'hBFC00200;
        dec_rdy = 1'b0; mem_rdy = 1'b1; flush = 1'b0;
        lat = 1; tick();
        lat = 2; tick();
        lat = 3; tick();
        flush = 1'b1; dec_rdy = 1'b1;
        tick();
        checks++;
        if (s_ivalid !== 1'b1) begin
            failures++;
            $display("FAIL fc_head: got ivalid=%b want 1", s_ivalid);
        end
        flush = 1'b0; lat = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_ivalid !== 1'b0) begin
                failures++;
                $display("FAIL fc_discard: cycle %0d got ivalid=%b pc=%h want 0", i, s_ivalid, s_ipc);
            end
        end
        wait_first_pop("fc", target);
        drain("fc");
        acc = 0;
        mem_rdy = 1'b1; dec_rdy = 1'b0; lat = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_acc) acc++;
        end
        checks++;
        if (acc != int'(DEPTH_TB)) begin
            failures++;
            $display("FAIL fc_credits: got %0d accepted want %0d", acc, DEPTH_TB);
        end
        drain("fc2");
    endtask

    task automatic test_async_reset();
        mem_rdy = 1'b1; dec_rdy = 1'b1; flush = 1'b0; lat = 2;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid_o, fetch_stall_o, instr_valid_o} !== 3'b000 ||
            instr_o !== 32'd0 || instr_pc_o !== 32'd0 || instr_pc_plus4_o !== 32'd0) begin
            failures++;
            $display("FAIL ar_immediate: got req=%b stall=%b ivalid=%b instr=%h pc=%h want all 0",
                     imem_req_valid_o, fetch_stall_o, instr_valid_o, instr_o, instr_pc_o);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_ivalid !== 1'b0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL ar_stale: got ivalid=%b req=%b want 0 0", s_ivalid, s_valid);
            end
        end
        mq_addr.delete(); mq_due.delete(); sb_pc.delete();
        rst = 1'b0;
        pc  = RESET_PC;
        mem_rdy = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== RESET_PC || s_ivalid !== 1'b0) begin
            failures++;
            $display("FAIL ar_release: got req=%b addr=%h ivalid=%b want 1 %h 0", s_valid, s_addr, s_ivalid, RESET_PC);
        end
        wait_first_pop("ar", RESET_PC);
        drain("ar");
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; lat = 1;
        rst = 1'b1; flush = 1'b0; mem_rdy = 1'b0; dec_rdy = 1'b0;
        pc = RESET_PC; target = RESET_PC;
        PC_i = RESET_PC; PC_Plus4_i = RESET_PC + 32'd4; flush_i = 1'b0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = INSTR_NOP;
        instr_ready_i = 1'b0;
        test_reset();
        test_zero_wait();
        test_decode_backpressure();
        test_mem_backpressure();
        test_flush_inflight();
        test_flush_coincident();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Consumer side of the program counter. Takes the current PC and PC+4 from the PC register and issues in-order read requests to instruction memory over a valid/ready interface. It pairs each returned word with the PC that fetched it and buffers the pairs in a small queue toward decode. A redirect (PCsrc from execute) flushes queued words and discards responses already in flight.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction word
DEPTH, 2, max combined count of in-flight requests + queued instructions + responses pending discard; power of two, minimum 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
PC_i  in  DATA_WIDTH  current PC from PC register
PC_Plus4_i  in  DATA_WIDTH  PC+4 from PC register
flush_i  in  1  redirect taken in execute (PCsrc); PC register loads target next edge
imem_req_valid_o  out  1  fetch request valid
imem_req_addr_o  out  DATA_WIDTH  fetch address, equals PC_i
imem_req_ready_i  in  1  memory accepts request
imem_rsp_valid_i  in  1  response word valid; responses arrive in request order, at least 1 cycle after acceptance
imem_rsp_data_i  in  DATA_WIDTH  instruction word
instr_valid_o  out  1  decode-side valid
instr_o  out  DATA_WIDTH  instruction at queue head
instr_pc_o  out  DATA_WIDTH  PC of that instruction
instr_pc_plus4_o  out  DATA_WIDTH  PC+4 of that instruction
instr_ready_i  in  1  decode accepts head
fetch_stall_o  out  1  PC register must hold this cycle

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, drop counter 0, credit counter 0. imem_req_valid_o=0, instr_valid_o=0, fetch_stall_o=0. instr_o, instr_pc_o and instr_pc_plus4_o read 0.
- Credits: used = inflight + queued + drop. A request may issue only when used < DEPTH.
- imem_req_valid_o = !flush_i && (used < DEPTH). The output is combinational; address = PC_i.
- Acceptance happens on imem_req_valid_o && imem_req_ready_i. On acceptance, push {PC_i, PC_Plus4_i} into the tag FIFO.
- fetch_stall_o = !flush_i && !(imem_req_valid_o && imem_req_ready_i). On flush the PC register must load the target, so stall is never asserted during flush.
- Response while drop > 0: discard the word, pop the tag FIFO, decrement drop.
- Response while drop = 0: pop the tag, push {word, tag} into the output FIFO. The output FIFO cannot overflow because of the credit rule.
- A response may be pushed and the head popped in the same cycle. Instruction-to-decode latency is 1 cycle after the response.
- Decode handshake: pop the output FIFO on instr_valid_o && instr_ready_i. Head fields stay stable while valid && !ready.
- Flush cycle:
  - Output FIFO cleared, including any simultaneous response push or decode pop.
  - drop <= inflight after this cycle's response. A response arriving in the flush cycle is itself discarded and popped.
  - No request issues in the flush cycle. The first request at the target address issues the next cycle.
- Flush asserted in consecutive cycles: each cycle re-applies the above. This is idempotent.
- Response with empty tag FIFO: protocol violation. Ignore it and raise a simulation assertion.
- Counters are saturating-free. Width is $clog2(DEPTH)+1 and the credit rule keeps them bounded.
- Reset mid-operation: everything cleared immediately. Responses arriving after reset release with no outstanding tag are ignored per the rule above.

Decomposition:
- Package fetch_pkg holds:
  - RESET_PC = 32'hBFC00000
  - INSTR_NOP = 32'h00000013
  - typedef fetch_tag_t {pc, pc_plus4}
  - typedef fetch_entry_t {instr, pc, pc_plus4}
- Sub-module fetch_fifo: parameterised synchronous FIFO (width, depth) with push, pop, clear, full, empty and count. It is instantiated twice: tag FIFO and output FIFO.

Test Plan:
- Zero-wait memory: ready=1, responses 1 cycle after acceptance, decode ready=1, PC starting 0xBFC00000. Expected: instr_valid_o each cycle from cycle 2, instr_pc_o = 0xBFC00000, 0xBFC00004, ... and fetch_stall_o never asserted.
- Decode backpressure: instr_ready_i=0 for 5 cycles with DEPTH=2. Expected: after 2 accepted requests, imem_req_valid_o=0 and fetch_stall_o=1. Head holds 0xBFC00000 stable. Releasing ready resumes issue in order.
- Memory backpressure: imem_req_ready_i=0 for 3 cycles. Expected: fetch_stall_o=1 for those cycles, imem_req_addr_o held at the same PC, no tag pushed.
- Flush with 2 in flight: flush_i pulsed while 2 requests are outstanding and 1 entry is queued. Expected: queue empty next cycle, both late responses (e.g. 0xDEADBEEF) discarded, and the first delivered instruction carries the target PC (e.g. 0xBFC00100).
- Flush coincident with a response and a decode pop: no entry reaches decode, drop equals the remaining in-flight count, and the credit counter returns to 0 once all responses have drained.
- Async reset asserted mid-stream between clock edges: outputs go to 0 immediately. After release, the first request is at 0xBFC00000 and stale responses produce no instr_valid_o.
